// File: rtl/dither_fs.sv
`default_nettype none
// ============================================================================
// Module   : dither_fs
// Brief    : Floyd-Steinberg error-diffusion RGB quantiser (bypass/round/dither)
// Revision : 1.0
// ============================================================================
module dither_fs #(
   parameter int H_SIZE   = 607,
   parameter int V_SIZE   = 455,
   parameter int IN_BITS  = 6,
   parameter int OUT_BITS = 4,
   parameter int ERR_BITS = IN_BITS + 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              mode,
   input  logic                    in_valid,
   input  logic                    in_sof,
   input  logic [3*IN_BITS-1:0]    raw_rgb,
   output logic                    out_valid,
   output logic                    out_sof,
   output logic                    out_eol,
   output logic [3*OUT_BITS-1:0]   out_rgb
);
   localparam int c_d  = IN_BITS - OUT_BITS;
   localparam int c_xw = (H_SIZE > 1) ? $clog2(H_SIZE) : 1;
   localparam int c_yw = (V_SIZE > 1) ? $clog2(V_SIZE) : 1;
   localparam int c_ww = ERR_BITS + 4;
   localparam int c_half = 2 ** (c_d - 1);
   localparam logic signed [c_ww-1:0] c_emax  = c_ww'(2 ** (ERR_BITS - 1) - 1);
   localparam logic signed [c_ww-1:0] c_emin  = ~c_emax;
   localparam logic signed [c_ww-1:0] c_qmax  = c_ww'(2 ** OUT_BITS - 1);
   localparam logic signed [c_ww-1:0] c_elim  = c_ww'(2 ** c_d);
   localparam logic signed [c_ww-1:0] c_elimn = -c_elim;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

   state_t              r_state;
   logic [c_xw-1:0]     r_x;
   logic [c_yw-1:0]     r_y;
   logic [1:0]          r_mode;

   logic                w_start, w_proc, w_dither, w_round;
   logic                w_first_row, w_last_col, w_last_row;
   logic [c_xw-1:0]     w_x;
   logic [c_yw-1:0]     w_y;
   logic [1:0]          w_mode;
   logic [3*OUT_BITS-1:0] w_q;

   function automatic logic signed [ERR_BITS-1:0] f_sat(input logic signed [c_ww-1:0] v);
      if (v > c_emax)      return c_emax[ERR_BITS-1:0];
      else if (v < c_emin) return c_emin[ERR_BITS-1:0];
      else                 return v[ERR_BITS-1:0];
   endfunction

   // A frame-start pixel behaves as position (0,0) with fresh mode and no error
   assign w_start     = in_valid & in_sof;
   assign w_proc      = in_valid & (w_start | (r_state == S_ACTIVE));
   assign w_x         = w_start ? '0 : r_x;
   assign w_y         = w_start ? '0 : r_y;
   assign w_mode      = w_start ? mode : r_mode;
   assign w_dither    = w_mode[1];
   assign w_round     = (w_mode == 2'b01);
   assign w_first_row = (w_y == '0);
   assign w_last_col  = (w_x == c_xw'(H_SIZE - 1));
   assign w_last_row  = (w_y == c_yw'(V_SIZE - 1));

   for (genvar c = 0; c < 3; c++) begin : g_ch
      logic [IN_BITS-1:0]          w_in;
      logic signed [ERR_BITS-1:0]  r_right, r_pend0, r_pend1;
      logic signed [ERR_BITS-1:0]  r_buf [H_SIZE];
      logic signed [ERR_BITS-1:0]  w_right, w_pend0, w_row, w_acc;
      logic signed [c_ww-1:0]      w_inw, w_sum, w_val, w_qw, w_err, w_ec;
      logic signed [c_ww-1:0]      w_e3, w_e5, w_e7;
      logic [OUT_BITS-1:0]         w_qs;

      assign w_in    = raw_rgb[c*IN_BITS +: IN_BITS];
      assign w_inw   = $signed({{(c_ww-IN_BITS){1'b0}}, w_in});
      assign w_right = w_start ? '0 : r_right;
      assign w_pend0 = w_start ? '0 : r_pend0;
      assign w_row   = w_first_row ? '0 : r_buf[w_x];
      assign w_acc   = f_sat(c_ww'(w_right) + c_ww'(w_row));
      assign w_sum   = w_inw + ((c_ww'(w_acc) + c_ww'(8)) >>> 4);

      // Rounding is the dither datapath with zero accumulated error
      assign w_val   = w_dither ? w_sum : w_inw;
      assign w_qw    = (w_val + c_ww'(c_half)) >>> c_d;
      assign w_qs    = (w_qw < 0) ? '0 : ((w_qw > c_qmax) ? c_qmax[OUT_BITS-1:0] : w_qw[OUT_BITS-1:0]);
      assign w_err   = w_val - $signed({{(c_ww-OUT_BITS){1'b0}}, w_qs} << c_d);
      assign w_ec    = (w_err > c_elim) ? c_elim : ((w_err < c_elimn) ? c_elimn : w_err);
      assign w_e3    = (w_ec <<< 1) + w_ec;
      assign w_e5    = (w_ec <<< 2) + w_ec;
      assign w_e7    = (w_ec <<< 3) - w_ec;

      assign w_q[c*OUT_BITS +: OUT_BITS] =
         (w_dither | w_round) ? w_qs : w_in[IN_BITS-1:c_d];

      // r_pend0 holds DR(x-1) for column x; r_pend1 holds DR(x-2)+DC(x-1) for column x-1
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_right <= '0;
            r_pend0 <= '0;
            r_pend1 <= '0;
         end else if (w_proc) begin
            if (w_dither) begin
               r_right <= w_last_col ? '0 : f_sat(w_e7);
               r_pend0 <= w_last_col ? '0 : f_sat(w_ec);
               r_pend1 <= f_sat(c_ww'(w_pend0) + w_e5);
            end else begin
               r_right <= '0;
               r_pend0 <= '0;
               r_pend1 <= '0;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (w_proc && w_dither && !w_last_row) begin
            if (w_x != '0)
               r_buf[w_x - 1'b1] <= f_sat(c_ww'(r_pend1) + w_e3);
            if (w_last_col)
               r_buf[H_SIZE-1] <= f_sat(c_ww'(w_pend0) + w_e5);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_x       <= '0;
         r_y       <= '0;
         r_mode    <= 2'b00;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
         out_rgb   <= '0;
      end else begin
         out_valid <= w_proc;
         out_sof   <= w_start;
         out_eol   <= w_proc & w_last_col;
         if (w_proc) begin
            out_rgb <= w_q;
            r_mode  <= w_mode;
            if (w_last_col) begin
               r_x <= '0;
               if (w_last_row) begin
                  r_y     <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_y     <= w_y + 1'b1;
                  r_state <= S_ACTIVE;
               end
            end else begin
               r_x     <= w_x + 1'b1;
               r_y     <= w_y;
               r_state <= S_ACTIVE;
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_dither_fs.sv
`default_nettype none
// ============================================================================
// Module   : tb_dither_fs
// Brief    : Scoreboard bench for dither_fs (4x3 image, 6->4 bits)
// Revision : 1.0
// ============================================================================
module tb_dither_fs;
   localparam int H  = 4;
   localparam int V  = 3;
   localparam int IB = 6;
   localparam int OB = 4;

   logic            clk      = 1'b0;
   logic            reset    = 1'b1;
   logic [1:0]      mode     = 2'b00;
   logic            in_valid = 1'b0;
   logic            in_sof   = 1'b0;
   logic [3*IB-1:0] raw_rgb  = '0;
   logic            out_valid, out_sof, out_eol;
   logic [3*OB-1:0] out_rgb;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [13:0] sb_q[$];
   logic [13:0] exp_w;

   int          m_right [3];
   int          m_cur [3][H];
   int          m_nxt [3][H];
   bit          m_act  = 1'b0;
   int          m_x    = 0;
   int          m_y    = 0;
   logic [1:0]  m_mode = 2'b00;

   dither_fs #(
      .H_SIZE(H), .V_SIZE(V), .IN_BITS(IB), .OUT_BITS(OB), .ERR_BITS(IB + 4)
   ) dut (
      .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_sof(in_sof),
      .raw_rgb(raw_rgb), .out_valid(out_valid), .out_sof(out_sof),
      .out_eol(out_eol), .out_rgb(out_rgb)
   );

   always #5 clk = ~clk;

   function automatic int sat_e(input int v);
      if (v > 511)  return 511;
      if (v < -512) return -512;
      return v;
   endfunction

   // Frame-level reference: errors scattered straight into next-row array
   task automatic model_px(input logic sof, input logic [17:0] rgb);
      logic [11:0] q_all;
      int pv, acc, sum, q, e;
      if (sof) begin
         m_act = 1'b1; m_x = 0; m_y = 0; m_mode = mode;
         for (int c = 0; c < 3; c++) begin
            m_right[c] = 0;
            for (int k = 0; k < H; k++) begin m_cur[c][k] = 0; m_nxt[c][k] = 0; end
         end
      end
      if (!m_act) return;
      q_all = '0;
      for (int c = 0; c < 3; c++) begin
         pv = int'(rgb[c*6 +: 6]);
         if (m_mode == 2'b00) begin
            q = pv / 4;
         end else if (m_mode == 2'b01) begin
            q = (pv + 2) / 4;
            if (q > 15) q = 15;
         end else begin
            acc = sat_e(m_right[c] + ((m_y == 0) ? 0 : m_cur[c][m_x]));
            sum = pv + ((acc + 8) >>> 4);
            q = (sum + 2) >>> 2;
            if (q < 0) q = 0;
            if (q > 15) q = 15;
            e = sum - 4 * q;
            if (e > 4) e = 4;
            if (e < -4) e = -4;
            m_right[c] = (m_x == H - 1) ? 0 : sat_e(7 * e);
            if (m_y != V - 1) begin
               if (m_x > 0)     m_nxt[c][m_x-1] = sat_e(m_nxt[c][m_x-1] + 3 * e);
               m_nxt[c][m_x] = sat_e(m_nxt[c][m_x] + 5 * e);
               if (m_x < H - 1) m_nxt[c][m_x+1] = sat_e(m_nxt[c][m_x+1] + e);
            end
         end
         q_all[c*4 +: 4] = 4'(q);
      end
      sb_q.push_back({sof, (m_x == H - 1), q_all});
      if (m_x == H - 1) begin
         m_x = 0;
         if (m_y == V - 1) m_act = 1'b0;
         else begin
            m_y++;
            for (int c = 0; c < 3; c++)
               for (int k = 0; k < H; k++) begin m_cur[c][k] = m_nxt[c][k]; m_nxt[c][k] = 0; end
         end
      end else m_x++;
   endtask

   task automatic model_reset();
      m_act = 1'b0; m_x = 0; m_y = 0; m_mode = 2'b00;
      sb_q.delete();
   endtask

   // Drive one cycle; outputs are sampled 1 time unit after the edge
   task automatic send(input logic v, input logic sof, input logic [17:0] rgb);
      if (v) model_px(sof, rgb);
      in_valid = v; in_sof = sof; raw_rgb = rgb;
      @(posedge clk); #1;
      in_valid = 1'b0; in_sof = 1'b0;
   endtask

   task automatic test_reset();
      #3 reset = 1'b0; #1;
      n_cmp++;
      if ({out_valid, out_sof, out_eol, out_rgb} !== 15'h0) begin
         n_err++; $display("FAIL reset_init: outputs=%h required 0", {out_valid, out_sof, out_eol, out_rgb});
      end
      @(negedge clk) reset = 1'b1;
      mode = 2'b00;
      for (int i = 0; i < 3; i++) begin
         send(1'b1, i == 0, {3{6'h2B}});
         n_cmp++;
         if (sb_q.size() == 0) begin n_err++; $display("FAIL reset_pre px%0d: scoreboard empty", i); end
         else begin
            exp_w = sb_q.pop_front();
            if ({out_valid, out_sof, out_eol, out_rgb} !== {1'b1, exp_w}) begin
               n_err++; $display("FAIL reset_pre px%0d: got %h required %h", i, {out_valid, out_sof, out_eol, out_rgb}, {1'b1, exp_w});
            end
         end
      end
      #2 reset = 1'b0; #1;
      n_cmp++;
      if (out_valid !== 1'b0 || out_rgb !== 12'h000 || out_sof !== 1'b0) begin
         n_err++; $display("FAIL reset_async: valid=%b rgb=%h required 0/000", out_valid, out_rgb);
      end
      model_reset();
      @(negedge clk) reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         send(1'b1, 1'b0, 18'($urandom));
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_idle px%0d: out_valid=%b required 0", i, out_valid);
         end
      end
   endtask

   task automatic test_bypass();
      mode = 2'b00;
      for (int i = 0; i < H * V; i++) begin
         send(1'b1, i == 0, {3{6'h2B}});
         n_cmp++;
         if (sb_q.size() == 0) begin n_err++; $display("FAIL bypass px%0d: scoreboard empty", i); end
         else begin
            exp_w = sb_q.pop_front();
            if ({out_valid, out_sof, out_eol, out_rgb} !== {1'b1, exp_w}) begin
               n_err++; $display("FAIL bypass px%0d: got %h required %h", i, {out_valid, out_sof, out_eol, out_rgb}, {1'b1, exp_w});
            end
         end
         n_cmp++;
         if (out_rgb !== 12'hAAA) begin n_err++; $display("FAIL bypass_const px%0d: got %h required AAA", i, out_rgb); end
      end
   endtask

   task automatic test_round();
      mode = 2'b01;
      for (int i = 0; i < H * V; i++) begin
         send(1'b1, i == 0, {6'd42, 6'd63, 6'd1});
         n_cmp++;
         if (sb_q.size() == 0) begin n_err++; $display("FAIL round px%0d: scoreboard empty", i); end
         else begin
            exp_w = sb_q.pop_front();
            if ({out_valid, out_sof, out_eol, out_rgb} !== {1'b1, exp_w}) begin
               n_err++; $display("FAIL round px%0d: got %h required %h", i, {out_valid, out_sof, out_eol, out_rgb}, {1'b1, exp_w});
            end
         end
         n_cmp++;
         if (out_rgb !== 12'hBF0) begin n_err++; $display("FAIL round_const px%0d: got %h required BF0", i, out_rgb); end
      end
   endtask

   task automatic test_dither_flat();
      mode = 2'b10;
      for (int i = 0; i < H * V; i++) begin
         send(1'b1, i == 0, {3{6'd42}});
         n_cmp++;
         if (sb_q.size() == 0) begin n_err++; $display("FAIL flat px%0d: scoreboard empty", i); end
         else begin
            exp_w = sb_q.pop_front();
            if ({out_valid, out_sof, out_eol, out_rgb} !== {1'b1, exp_w}) begin
               n_err++; $display("FAIL flat px%0d: got %h required %h", i, {out_valid, out_sof, out_eol, out_rgb}, {1'b1, exp_w});
            end
         end
         if (i < H) begin
            n_cmp++;
            if (out_rgb !== ((i % 2 == 0) ? 12'hBBB : 12'hAAA)) begin
               n_err++; $display("FAIL flat_row0 x%0d: got %h required %h", i, out_rgb, (i % 2 == 0) ? 12'hBBB : 12'hAAA);
            end
         end
      end
   endtask

   task automatic test_gaps();
      int gaps;
      mode = 2'b10;
      for (int i = 0; i < H * V; i++) begin
         gaps = (i == 0) ? 0 : int'($urandom_range(0, 3));
         for (int g = 0; g < gaps; g++) begin
            send(1'b0, 1'($urandom), 18'($urandom));
            n_cmp++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL gap px%0d: out_valid=%b required 0", i, out_valid); end
         end
         send(1'b1, i == 0, {3{6'd42}});
         n_cmp++;
         if (sb_q.size() == 0) begin n_err++; $display("FAIL gaps px%0d: scoreboard empty", i); end
         else begin
            exp_w = sb_q.pop_front();
            if ({out_valid, out_sof, out_eol, out_rgb} !== {1'b1, exp_w}) begin
               n_err++; $display("FAIL gaps px%0d: got %h required %h", i, {out_valid, out_sof, out_eol, out_rgb}, {1'b1, exp_w});
            end
         end
      end
   endtask

   task automatic test_restart();
      mode = 2'b10;
      for (int i = 0; i < 6 + H * V; i++) begin
         send(1'b1, (i == 0) || (i == 6), {3{6'd42}});
         n_cmp++;
         if (sb_q.size() == 0) begin n_err++; $display("FAIL restart px%0d: scoreboard empty", i); end
         else begin
            exp_w = sb_q.pop_front();
            if ({out_valid, out_sof, out_eol, out_rgb} !== {1'b1, exp_w}) begin
               n_err++; $display("FAIL restart px%0d: got %h required %h", i, {out_valid, out_sof, out_eol, out_rgb}, {1'b1, exp_w});
            end
         end
         if (i == 6) begin
            n_cmp++;
            if (out_sof !== 1'b1 || out_rgb !== 12'hBBB) begin
               n_err++; $display("FAIL restart_px: sof=%b rgb=%h required 1/BBB", out_sof, out_rgb);
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         send(1'b1, 1'b0, {3{6'd42}});
         n_cmp++;
         if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_frame px%0d: out_valid=%b required 0", i, out_valid); end
      end
   endtask

   task automatic test_random();
      logic [17:0] px;
      mode = 2'b11;
      for (int i = 0; i < H * V; i++) begin
         for (int c = 0; c < 3; c++) begin
            case ($urandom_range(0, 3))
               0:       px[c*6 +: 6] = 6'd0;
               1:       px[c*6 +: 6] = 6'd63;
               default: px[c*6 +: 6] = 6'($urandom);
            endcase
         end
         send(1'b1, i == 0, px);
         n_cmp++;
         if (sb_q.size() == 0) begin n_err++; $display("FAIL random px%0d: scoreboard empty", i); end
         else begin
            exp_w = sb_q.pop_front();
            if ({out_valid, out_sof, out_eol, out_rgb} !== {1'b1, exp_w}) begin
               n_err++; $display("FAIL random px%0d in=%h: got %h required %h", i, px, {out_valid, out_sof, out_eol, out_rgb}, {1'b1, exp_w});
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_round();
      test_dither_flat();
      test_gaps();
      test_restart();
      test_random();
      n_cmp++;
      if (sb_q.size() != 0) begin n_err++; $display("FAIL drain: %0d entries left, required 0", sb_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
`default_nettype wire

// File: doc/dither_fs.md
# dither_fs

Parametrised Floyd–Steinberg error-diffusion quantiser. It sits between the camera/frame-buffer pixel stream and the VGA colour DAC, and reduces each RGB channel from IN_BITS to OUT_BITS. Over the fixed 607×455, 6→4-bit dither stage it adds:
- generic widths and image size;
- a valid-qualified stream with gaps allowed;
- frame-start restart;
- run-time mode select: bypass, round, or dither.

Diffused error is kept in one line-buffer memory per channel instead of a frame-wide shift register.

## Interface
- H_SIZE, 607, active pixels per line (≥2)
- V_SIZE, 455, active lines per frame (≥2)
- IN_BITS, 6, input bits per channel
- OUT_BITS, 4, output bits per channel; IN_BITS−OUT_BITS = D ≥ 1
- ERR_BITS, IN_BITS+4, signed width of accumulated error, in 1/16 input-LSB units

Ports:
- clk  in  1  pixel clock; all logic on posedge
- reset  in  1  asynchronous, active-low reset
- mode  in  2  00 bypass, 01 round, 10 dither, 11 treated as 10; sampled only on a frame-start pixel
- in_valid  in  1  pixel present on raw_rgb
- in_sof  in  1  first pixel of frame; qualified by in_valid
- raw_rgb  in  3*IN_BITS  {R,G,B}, unsigned
- out_valid  out  1  pixel present on out_rgb
- out_sof  out  1  out_rgb is the first pixel of a frame
- out_eol  out  1  out_rgb is the last pixel of a line
- out_rgb  out  3*OUT_BITS  {R,G,B} quantised

## Operation
- State machine: IDLE, ACTIVE.
  - IDLE: ignore all pixels. On in_valid&in_sof, go to ACTIVE: x=0, y=0, latch mode, process that pixel.
  - ACTIVE: each in_valid pixel is processed, then x++. At x=H_SIZE−1: x←0, y++. After pixel (H_SIZE−1, V_SIZE−1): go to IDLE.
  - in_valid&in_sof while ACTIVE: restart as from IDLE. All pending error is discarded.
  - in_valid=0: all state holds; no output.
- Per channel, per pixel (x,y):
  - acc = right_err + (y==0 ? 0 : rowbuf[x]), sign-extended to ERR_BITS.
  - sum = in + ((acc+8)>>>4), signed.
  - q = (sum + 2^(D−1)) >>> D, saturated to [0, 2^OUT_BITS−1].
  - err = sum − (q<<D), clamped to ±(2^D).
- Error distribution, in 1/16 units:
  - 7·err → right_err for x+1.
  - 3·err → next row x−1.
  - 5·err → next row x.
  - 1·err → next row x+1.
- Edges:
  - x=H_SIZE−1: right and down-right shares dropped; right_err←0.
  - x=0: down-left share dropped.
  - y=V_SIZE−1: all next-row shares dropped.
- Line buffer: H_SIZE×ERR_BITS per channel.
  - Read index x; write index x−1, which completes DL(x)+DC(x−1)+DR(x−2).
  - The write for index H_SIZE−1 happens at the line's last pixel.
  - Read-before-write on the same address is not required. Addresses always differ.
- Accumulator arithmetic saturates at ERR_BITS limits; it never wraps.
- Modes:
  - bypass: q = in>>D; no error is stored.
  - round: q = saturated round of in; no error is stored.
  - dither: full algorithm.

## Timing
- Reset values: out_valid=0, out_sof=0, out_eol=0, out_rgb=0, state IDLE, x=y=0, right_err=0, latched mode=00. Buffer contents are undefined; they are masked by the y==0 rule.
- Latency: exactly 1 clk. The out_* registers load on every cycle with in_valid accepted in ACTIVE (or at the frame start).
- out_valid=0 in every other cycle; out_rgb holds its last value.
- Throughput: 1 pixel/clk sustained. Any in_valid gap pattern yields identical output values.
- out_sof=1 with the output of a frame-start pixel. out_eol=1 with the output of x=H_SIZE−1.
- Reset asserted mid-frame: outputs clear immediately (async). After release, the block waits in IDLE for in_sof.

## Test plan
(Test parameters: H_SIZE=4, V_SIZE=3, IN_BITS=6, OUT_BITS=4.)
- Reset: assert reset=0 mid-stream → out_valid=0, out_rgb=0 within the same cycle. Pixels without in_sof after release → no out_valid.
- Bypass: mode=00, all channels 6'h2B → out_rgb=12'hAAA, 1 clk after each in_valid. out_sof on pixel 0; out_eol on x=3.
- Round/saturate: mode=01; R=42, G=63, B=1 → R=11, G=15, B=0.
- Dither flat field: mode=10, all channels 42, back-to-back → row 0 outputs per channel 11,10,11,10.
- Repeat the flat field with random in_valid gaps → outputs bit-identical to the gapless run.
- Restart: in_sof at pixel (2,1) mid-frame → output from that pixel equals a fresh frame (11,10,…). out_sof=1 on it.
